// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: word type, FIFO entry layout and reset PC.
package fetch_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic word_t pc_plus4(input word_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: imem request/response channel, redirect from execute, decode handoff.
interface fetch_if;
    import fetch_pkg::*;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [29:0] imem_req_addr;
    logic        imem_rsp_valid;
    word_t       imem_rsp_data;
    logic        redirect;
    word_t       redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    word_t       dec_instr;
    word_t       dec_pc;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, dec_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; extra pointer MSB distinguishes full from empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output T                       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T             mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
            if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-based imem issue, prefetch FIFO, redirect flush.
// Define FETCH_PERF_EN to add the saturating stall_cnt output.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int    DEPTH    = 4,
    parameter word_t RESET_PC = RESET_PC_DEFAULT,
    parameter int    MAX_OUT  = DEPTH
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.master bus
`ifdef FETCH_PERF_EN
    ,
    output word_t  stall_cnt
`endif
);

    localparam int CW        = $clog2(DEPTH) + 2;
    localparam int TAG_DEPTH = (MAX_OUT <= 2) ? 2 : (1 << $clog2(MAX_OUT));
    localparam int TCW       = $clog2(TAG_DEPTH) + 1;
    localparam int FCW       = $clog2(DEPTH) + 1;

    word_t           fetch_pc;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   fifo_level;

    logic            req_valid;
    logic            fire;
    logic            rsp_stale;
    logic            rsp_keep;
    logic            dec_pop;

    word_t           tag_pc;
    logic            tag_full;
    logic            tag_empty;
    logic [TCW-1:0]  tag_count;

    fetch_entry_t    push_entry;
    fetch_entry_t    head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FCW-1:0]  fifo_count;

    // Every in-flight request is either tagged (live) or counted in drop (stale).
    assign outstanding = CW'(tag_count) + drop;
    assign fifo_level  = CW'(fifo_count);

    assign req_valid = rst_n && !bus.redirect
                     && ((outstanding + fifo_level) < CW'(DEPTH))
                     && (outstanding < CW'(MAX_OUT));
    assign fire      = req_valid && bus.imem_req_ready;
    assign rsp_stale = bus.imem_rsp_valid && (drop != '0);
    assign rsp_keep  = bus.imem_rsp_valid && (drop == '0);
    assign dec_pop   = !fifo_empty && bus.dec_ready;

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc[31:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc & ~32'h3;
        end else if (fire) begin
            fetch_pc <= pc_plus4(fetch_pc);
        end
    end

    // On redirect every request still in flight after this cycle becomes stale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop <= '0;
        end else if (bus.redirect) begin
            drop <= outstanding - CW'(bus.imem_rsp_valid);
        end else if (rsp_stale) begin
            drop <= drop - CW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (TAG_DEPTH),
        .T     (word_t)
    ) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fire),
        .push_data (fetch_pc),
        .pop       (rsp_keep),
        .flush     (bus.redirect),
        .head      (tag_pc),
        .full      (tag_full),
        .empty     (tag_empty),
        .count     (tag_count)
    );

    assign push_entry = '{pc: tag_pc, instr: bus.imem_rsp_data};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_instr_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_keep),
        .push_data (push_entry),
        .pop       (dec_pop),
        .flush     (bus.redirect),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.dec_valid = !fifo_empty;
    assign bus.dec_pc    = fifo_empty ? '0 : head.pc;
    assign bus.dec_instr = fifo_empty ? '0 : head.instr;

`ifdef FETCH_PERF_EN
    function automatic word_t sat_inc(input word_t v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (bus.dec_ready && fifo_empty) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

    // Space is reserved at issue, so these can only fire on a protocol violation.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && fifo_full));
    a_tag_room:    assert property (@(posedge clk) disable iff (!rst_n) !(fire && tag_full));
    a_tag_match:   assert property (@(posedge clk) disable iff (!rst_n) !(rsp_keep && tag_empty));

endmodule
